// File: rtl/gru_pkg.sv
// Shared constants, state encoding and helpers for the UART run sequencer.
// Frame geometry derives from N_STEPS/N_FEAT/DATA_W.
package gru_pkg;

  localparam int N_STEPS = 7;
  localparam int N_FEAT  = 3;
  localparam int DATA_W  = 32;
  localparam int N_WORDS = N_STEPS * N_FEAT;
  localparam int SEQ_W   = N_WORDS * DATA_W;
  localparam int NB      = N_WORDS * (DATA_W / 8);
  localparam int CNT_W   = $clog2(NB);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] TMO_BYTE  = 8'hEE;

  localparam logic [DATA_W-1:0] FP_ONE = 32'h3F800000;

  typedef enum logic [2:0] {
    S_HUNT,
    S_PAY,
    S_CHK,
    S_START,
    S_RUN,
    S_TXA,
    S_TXD,
    S_TXE
  } state_t;

  function automatic logic [SEQ_W-1:0] seq_fill(input logic [DATA_W-1:0] w);
    return {N_WORDS{w}};
  endfunction

endpackage

// File: rtl/gru_frame_rx.sv
// Frame receiver: hunts for SYNC, collects payload into a shadow buffer, checks XOR.
// frame_ok/frame_bad are combinational in the CHK byte cycle; seq_flat updates at that edge.
module gru_frame_rx
  import gru_pkg::*;
#(
  parameter int RX_GAP_CYC = 50000
)
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic             sync_det,
  output logic             rx_busy,
  output logic [SEQ_W-1:0] seq_flat
);

  localparam int GAP_W = $clog2(RX_GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [7:0]         acc, acc_nxt;
  logic [GAP_W-1:0]   gap, gap_nxt;
  logic [SEQ_W-1:0]   shadow;
  logic               gap_expired;

  assign gap_expired = (gap == GAP_LAST);
  assign rx_busy     = (state != S_HUNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_HUNT;
      cnt      <= '0;
      acc      <= '0;
      gap      <= '0;
      seq_flat <= seq_fill(FP_ONE);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      gap   <= gap_nxt;
      if (frame_ok) begin
        seq_flat <= shadow;
      end
    end
  end

  // Byte b of the payload lands at bits [8b+7:8b], giving little-endian words.
  always_ff @(posedge clk) begin
    if (rx_valid && (state == S_PAY)) begin
      shadow[{cnt, 3'b000} +: 8] <= rx_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    gap_nxt   = gap;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    sync_det  = 1'b0;
    case (state)
      S_HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          sync_det  = 1'b1;
          state_nxt = S_PAY;
          cnt_nxt   = '0;
          acc_nxt   = '0;
          gap_nxt   = '0;
        end
      end
      S_PAY: begin
        if (rx_valid) begin
          acc_nxt = acc ^ rx_data;
          gap_nxt = '0;
          if (cnt == CNT_LAST) begin
            state_nxt = S_CHK;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (gap_expired) begin
          state_nxt = S_HUNT;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          state_nxt = S_HUNT;
          if (rx_data == acc) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end else if (gap_expired) begin
          state_nxt = S_HUNT;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
      default: state_nxt = S_HUNT;
    endcase
  end

endmodule

// File: rtl/gru_uart_run_sequencer.sv
// Top sequencer: frame receive, model start/watchdog, response frame over a valid/ready TX port.
// Good CHK in cycle T -> start pulse in T+1; TX bytes held stable until i_tx_ready.
module gru_uart_run_sequencer
  import gru_pkg::*;
#(
  parameter int RX_GAP_CYC  = 50000,
  parameter int RUN_TMO_CYC = 1000000
)
(
  input  logic              CLOCK_50,
  input  logic              rstn,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_start_model,
  input  logic              i_model_done,
  output logic [SEQ_W-1:0]  o_input_seq_flat,
  input  logic [DATA_W-1:0] i_prediction,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int WDOG_W = $clog2(RUN_TMO_CYC);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(RUN_TMO_CYC - 1);

  state_t             state, state_nxt;
  logic [WDOG_W-1:0]  wdog, wdog_nxt;
  logic [DATA_W-1:0]  pred, pred_nxt;
  logic [1:0]         idx, idx_nxt;
  logic [7:0]         err, err_nxt;
  logic               frame_ok, frame_bad, sync_det, rx_busy;
  logic               rx_take;

  // The receiver only sees bytes while the run/TX side is idle.
  assign rx_take = i_rx_valid && (state == S_HUNT);

  gru_frame_rx #(
    .RX_GAP_CYC (RX_GAP_CYC)
  ) u_frame_rx (
    .clk       (CLOCK_50),
    .rstn      (rstn),
    .rx_data   (i_rx_data),
    .rx_valid  (rx_take),
    .frame_ok  (frame_ok),
    .frame_bad (frame_bad),
    .sync_det  (sync_det),
    .rx_busy   (rx_busy),
    .seq_flat  (o_input_seq_flat)
  );

  assign o_busy = (state != S_HUNT) || rx_busy;

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state     <= S_HUNT;
      wdog      <= '0;
      pred      <= '0;
      idx       <= '0;
      err       <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      pred  <= pred_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
      if (i_rx_valid && (state != S_HUNT)) begin
        o_overrun <= 1'b1;
      end else if (sync_det) begin
        o_overrun <= 1'b0;
      end
    end
  end

  // Watchdog holds the number of cycles since the start pulse cycle.
  always_comb begin
    state_nxt     = state;
    wdog_nxt      = wdog;
    pred_nxt      = pred;
    idx_nxt       = idx;
    err_nxt       = err;
    o_start_model = 1'b0;
    o_tx_valid    = 1'b0;
    o_tx_data     = 8'h00;
    case (state)
      S_HUNT: begin
        wdog_nxt = '0;
        if (frame_ok) begin
          state_nxt = S_START;
        end else if (frame_bad) begin
          err_nxt   = NAK_BYTE;
          state_nxt = S_TXE;
        end
      end
      S_START: begin
        o_start_model = 1'b1;
        wdog_nxt      = wdog + 1'b1;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        if (i_model_done) begin
          pred_nxt  = i_prediction;
          state_nxt = S_TXA;
        end else if (wdog == WDOG_LAST) begin
          err_nxt   = TMO_BYTE;
          state_nxt = S_TXE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      S_TXA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = ACK_BYTE;
        if (i_tx_ready) begin
          idx_nxt   = 2'd0;
          state_nxt = S_TXD;
        end
      end
      S_TXD: begin
        o_tx_valid = 1'b1;
        o_tx_data  = pred[{idx, 3'b000} +: 8];
        if (i_tx_ready) begin
          if (idx == 2'd3) begin
            state_nxt = S_HUNT;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_TXE: begin
        o_tx_valid = 1'b1;
        o_tx_data  = err;
        if (i_tx_ready) begin
          state_nxt = S_HUNT;
        end
      end
      default: state_nxt = S_HUNT;
    endcase
  end

endmodule

// File: tb/tb_gru_uart_run_sequencer.sv
// Directed bench for gru_uart_run_sequencer with shortened gap/watchdog timers.
module tb_gru_uart_run_sequencer;
  import gru_pkg::*;

  localparam int GAP = 200;
  localparam int TMO = 3000;

  logic              CLOCK_50 = 1'b0;
  logic              rstn = 1'b1;
  logic [7:0]        i_rx_data = 8'h00;
  logic              i_rx_valid = 1'b0;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready = 1'b1;
  logic              o_start_model;
  logic              i_model_done = 1'b0;
  logic [SEQ_W-1:0]  o_input_seq_flat;
  logic [DATA_W-1:0] i_prediction = '0;
  logic              o_busy;
  logic              o_overrun;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [7:0] tx_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #10 CLOCK_50 = ~CLOCK_50;

  gru_uart_run_sequencer #(
    .RX_GAP_CYC  (GAP),
    .RUN_TMO_CYC (TMO)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .rstn             (rstn),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .o_start_model    (o_start_model),
    .i_model_done     (i_model_done),
    .o_input_seq_flat (o_input_seq_flat),
    .i_prediction     (i_prediction),
    .o_busy           (o_busy),
    .o_overrun        (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: collects transferred bytes, counts start pulses, checks stall stability.
  always @(negedge CLOCK_50) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_vld", o_tx_valid, 1);
        check("tx_hold_dat", o_tx_data, prev_data);
      end
      if (o_start_model) start_cnt++;
      if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
    end
  end

  function automatic logic [SEQ_W-1:0] frame_seq(input int base);
    logic [SEQ_W-1:0] s;
    for (int k = 0; k < N_WORDS; k++) s[32*k +: 32] = base + k;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    i_rx_valid = 1'b0;
  endtask

  // Sends SYNC + n_pay payload bytes (+ CHK if the payload is complete); optional idle before byte gap_at.
  task automatic send_frame(input int base, input bit bad, input int n_pay, input int gap_at,
                            input int gap_len);
    logic [SEQ_W-1:0] s;
    logic [7:0] acc;
    logic [7:0] b;
    s   = frame_seq(base);
    acc = 8'h00;
    send_byte(SYNC_BYTE);
    for (int i = 0; i < n_pay; i++) begin
      if (i == gap_at) idle(gap_len);
      b   = s[8*i +: 8];
      acc = acc ^ b;
      send_byte(b);
    end
    if (n_pay == NB) send_byte(bad ? ~acc : acc);
  endtask

  task automatic pulse_done(input logic [31:0] p);
    i_prediction = p;
    i_model_done = 1'b1;
    idle(1);
    i_model_done = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input int max_cyc);
    int c = 0;
    while (tx_q.size() < n && c < max_cyc) begin
      idle(1);
      c++;
    end
    check(tag, tx_q.size(), n);
  endtask

  initial begin
    logic [7:0] exp_b[5];
    int n;

    // 1: reset values
    #5 rstn = 1'b0;
    #1;
    check("rst_seq_async", o_input_seq_flat === seq_fill(FP_ONE), 1);
    check("rst_tx_valid", o_tx_valid, 0);
    repeat (3) @(posedge CLOCK_50);
    #1 rstn = 1'b1;
    idle(5);
    check("idle_seq", o_input_seq_flat === seq_fill(FP_ONE), 1);
    check("idle_start_cnt", start_cnt, 0);
    check("idle_tx_valid", o_tx_valid, 0);
    check("idle_tx_data", o_tx_data, 0);
    check("idle_busy", o_busy, 0);
    check("idle_overrun", o_overrun, 0);

    // 2: good frame, done 100 cycles after start
    send_frame(0, 1'b0, NB, -1, 0);
    check("t2_start", o_start_model, 1);
    check("t2_seq", o_input_seq_flat === frame_seq(0), 1);
    check("t2_busy", o_busy, 1);
    idle(99);
    pulse_done(32'h40490FDB);
    wait_tx("t2_tx_count", 5, 40);
    exp_b = '{8'h06, 8'hDB, 8'h0F, 8'h49, 8'h40};
    for (int i = 0; i < 5; i++) check("t2_tx_byte", tx_q[i], exp_b[i]);
    check("t2_start_cnt", start_cnt, 1);
    check("t2_word5", o_input_seq_flat[5*32 +: 32], 5);
    idle(2);
    check("t2_busy_end", o_busy, 0);
    check("t2_tx_valid_end", o_tx_valid, 0);

    // 3: bad checksum -> NAK, no start, sequence unchanged
    tx_q.delete();
    send_frame(7, 1'b1, NB, -1, 0);
    wait_tx("t3_tx_count", 1, 20);
    check("t3_nak", tx_q[0], NAK_BYTE);
    check("t3_start_cnt", start_cnt, 1);
    check("t3_seq_kept", o_input_seq_flat === frame_seq(0), 1);
    idle(3);
    check("t3_tx_count_end", tx_q.size(), 1);

    // 4: watchdog timeout; EE presented TMO cycles after the start pulse cycle
    tx_q.delete();
    send_frame(50, 1'b0, NB, -1, 0);
    check("t4_start", o_start_model, 1);
    n = 0;
    while (!o_tx_valid && n < TMO + 20) begin
      idle(1);
      n++;
    end
    check("t4_wdog_cycles", n, TMO);
    wait_tx("t4_tx_count", 1, 10);
    check("t4_tmo_byte", tx_q[0], TMO_BYTE);
    check("t4_start_cnt", start_cnt, 2);
    idle(2);
    check("t4_busy_end", o_busy, 0);
    pulse_done(32'h11111111);
    idle(3);
    check("t4_late_done_ignored", tx_q.size(), 1);

    // 5: truncated frame times out silently; next frame has a gap hitting the expiry cycle
    tx_q.delete();
    send_frame(200, 1'b0, 40, -1, 0);
    idle(GAP + 2);
    check("t5_abort_busy", o_busy, 0);
    check("t5_abort_tx", tx_q.size(), 0);
    check("t5_abort_seq", o_input_seq_flat === frame_seq(50), 1);
    send_frame(300, 1'b0, NB, 41, GAP - 1);
    check("t5_start", o_start_model, 1);
    check("t5_word0", o_input_seq_flat[0 +: 32], 300);
    check("t5_word20", o_input_seq_flat[20*32 +: 32], 320);
    idle(10);
    pulse_done(32'h12345678);
    wait_tx("t5_tx_count", 5, 40);
    exp_b = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 5; i++) check("t5_tx_byte", tx_q[i], exp_b[i]);
    check("t5_start_cnt", start_cnt, 3);

    // 6: overrun during run, stalled TX, async reset mid-transmission
    tx_q.delete();
    i_tx_ready = 1'b0;
    send_frame(400, 1'b0, NB, -1, 0);
    check("t6_start", o_start_model, 1);
    idle(3);
    send_byte(8'h55);
    check("t6_overrun", o_overrun, 1);
    check("t6_busy", o_busy, 1);
    idle(5);
    pulse_done(32'hCAFEF00D);
    exp_b = '{8'h06, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    for (int j = 0; j < 3; j++) begin
      idle(10);
      check("t6_stall_valid", o_tx_valid, 1);
      check("t6_stall_data", o_tx_data, exp_b[j]);
      i_tx_ready = 1'b1;
      idle(1);
      i_tx_ready = 1'b0;
    end
    idle(4);
    check("t6_pending_data", o_tx_data, 8'hFE);
    check("t6_tx_count", tx_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t6_tx_byte", tx_q[i], exp_b[i]);
    #3 rstn = 1'b0;
    #1;
    check("t6_rst_tx_valid", o_tx_valid, 0);
    check("t6_rst_tx_data", o_tx_data, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_overrun", o_overrun, 0);
    check("t6_rst_start", o_start_model, 0);
    check("t6_rst_seq", o_input_seq_flat === seq_fill(FP_ONE), 1);
    @(negedge CLOCK_50);
    #2 rstn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    i_tx_ready = 1'b1;
    idle(5);
    check("t6_abandoned", tx_q.size(), 3);
    check("t6_busy_after", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
